// File: rtl/uart_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_if
// Bus-side bundle of the queued UART transmitter.
//   writedata  data word to queue (DATA_BITS wide)
//   enable     write strobe
//   full       FIFO holds FIFO_DEPTH words
//   empty      FIFO holds no words
//   level      queued words, not counting the frame in flight
//   busy       transmitter FSM not idle
//   overflow   one-cycle pulse: a write was dropped because the FIFO was full
//   done       one-cycle pulse on the last clock of each frame
//   tx         serial line, idle high
// The master modport is the register/bus side; the slave modport is the
// transmitter itself.
// ----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] writedata;
    logic                 enable;
    logic                 full;
    logic                 empty;
    logic [LVL_W-1:0]     level;
    logic                 busy;
    logic                 overflow;
    logic                 done;
    logic                 tx;

    modport master (
        output writedata, enable,
        input  full, empty, level, busy, overflow, done, tx
    );

    modport slave (
        input  writedata, enable,
        output full, empty, level, busy, overflow, done, tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
// Parametrised UART transmitter with a small write FIFO in front of it.
// Frame: one idle guard bit, start bit, DATA_BITS data bits (LSB first),
// optional parity bit, STOP_BITS stop bits.
// Ports:
//   clock   system clock, rising edge
//   resetn  asynchronous active-low reset; aborts any frame in flight
//   bus     uart_tx_fifo_if slave: writedata/enable in,
//           full/empty/level/busy/overflow/done/tx out
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,     // 0 none, 1 odd, 2 even
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clock,
    input  logic          resetn,
    uart_tx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_GUARD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    // FIFO
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_overflow;

    // Transmitter
    state_t               r_state;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_done;
    logic                 r_busy;

    logic                 w_bit_end;
    logic                 w_last_stop;
    logic                 w_frame_end;
    logic                 w_pop;
    logic                 w_push;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_parity;
    logic [LVL_W-1:0]     w_level_nxt;

    assign w_bit_end   = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_last_stop = (r_state == S_STOP) && (r_bit_idx == IDX_W'(STOP_BITS - 1));
    assign w_frame_end = w_last_stop && w_bit_end;

    // A pop happens from IDLE, or straight out of the last stop clock so
    // queued frames follow each other with only the guard bit between them.
    assign w_pop  = !r_empty && ((r_state == S_IDLE) || w_frame_end);
    // A write while full is still accepted when a pop frees a slot on the same edge.
    assign w_push = bus.enable && (!r_full || w_pop);

    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_parity = (PARITY == 1) ? ~^w_head : ^w_head;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers and level define which entries are valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.writedata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            // Pointers are power-of-two wide, so they wrap on their own.
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == LVL_W'(FIFO_DEPTH));
            r_empty    <= (w_level_nxt == '0);
            r_overflow <= bus.enable && r_full && !w_pop;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            // Raised one clock early so done is high during the final stop clock.
            r_done <= w_last_stop && (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 2));

            if (r_state != S_IDLE) begin
                r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    r_tx      <= 1'b1;
                    if (w_pop) begin
                        r_shift  <= w_head;
                        r_parity <= w_head_parity;
                        r_busy   <= 1'b1;
                        r_state  <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            r_bit_idx <= '0;
                            if (PARITY != 0) begin
                                r_tx    <= r_parity;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_tx      <= 1'b1;
                        r_bit_idx <= '0;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_last_stop) begin
                            r_bit_idx <= '0;
                            if (w_pop) begin
                                r_shift  <= w_head;
                                r_parity <= w_head_parity;
                                r_state  <= S_GUARD;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.level    = r_level;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_overflow;
    assign bus.done     = r_done;
    assign bus.tx       = r_tx;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=16. Four instances cover
// 8N1 (a), 8E2 (b), 8O2 (c) and 7N1 (d). Outputs are sampled on the falling
// clock edge; frames are captured mid-bit starting from the start-bit edge.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    localparam int CPB = 16;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   sel;
    logic m_tx;
    logic m_done;

    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_b ();
    uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_c ();
    uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) if_d ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB)) dut_a (
        .clock(clk), .resetn(rst_n), .bus(if_a.slave));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clock(clk), .resetn(rst_n), .bus(if_b.slave));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(2)) dut_c (
        .clock(clk), .resetn(rst_n), .bus(if_c.slave));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7)) dut_d (
        .clock(clk), .resetn(rst_n), .bus(if_d.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial line and done of the instance currently under observation.
    always_comb begin
        m_tx   = 1'b1;
        m_done = 1'b0;
        case (sel)
            0: begin m_tx = if_a.tx; m_done = if_a.done; end
            1: begin m_tx = if_b.tx; m_done = if_b.done; end
            2: begin m_tx = if_c.tx; m_done = if_c.done; end
            3: begin m_tx = if_d.tx; m_done = if_d.done; end
            default: begin m_tx = 1'b1; m_done = 1'b0; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge. Waits for the start bit, captures nbits bits
    // mid-period (start bit in bit 0), and checks done fires once on the last
    // clock of the frame. Returns how many falling edges it waited for the start.
    task automatic check_frame(input string tag, input logic [15:0] exp_bits,
                               input int nbits, output int waited);
        logic [15:0] obs;
        int          done_cnt;
        int          done_at;
        int          len;
        obs      = '0;
        done_cnt = 0;
        done_at  = -1;
        len      = nbits * CPB;
        waited   = 0;
        while (m_tx !== 1'b0 && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " start seen"}, {31'd0, m_tx}, 32'd0);
        for (int n = 1; n <= len + 7; n++) begin
            @(negedge clk);
            if ((n % CPB) == CPB / 2 && (n / CPB) < nbits) obs[n / CPB] = m_tx;
            if (m_done === 1'b1) begin
                done_cnt++;
                done_at = n;
            end
        end
        check({tag, " bits"}, {16'd0, obs}, {16'd0, exp_bits});
        check({tag, " done count"}, done_cnt, 1);
        check({tag, " done position"}, done_at, len - 1);
    endtask

    logic [7:0]  t4_data [5];
    logic [15:0] t4_exp  [5];
    logic [7:0]  t6_data [5];
    logic [15:0] t6_exp  [5];
    int          w;
    int          k;
    int          cnt_done;
    int          cnt_low;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        sel      = 0;
        rst_n    = 1'b0;
        if_a.enable = 1'b0; if_a.writedata = '0;
        if_b.enable = 1'b0; if_b.writedata = '0;
        if_c.enable = 1'b0; if_c.writedata = '0;
        if_d.enable = 1'b0; if_d.writedata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst tx",       {31'd0, if_a.tx},       32'd1);
        check("rst busy",     {31'd0, if_a.busy},     32'd0);
        check("rst empty",    {31'd0, if_a.empty},    32'd1);
        check("rst full",     {31'd0, if_a.full},     32'd0);
        check("rst level",    {29'd0, if_a.level},    32'd0);
        check("rst overflow", {31'd0, if_a.overflow}, 32'd0);
        check("rst done",     {31'd0, if_a.done},     32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: 8N1, 0xAA -> start 0, data 0,1,0,1,0,1,0,1, stop 1
        if_a.writedata = 8'hAA;
        if_a.enable    = 1'b1;
        @(negedge clk);
        if_a.enable    = 1'b0;
        if_a.writedata = 8'h55;   // must not disturb the queued word
        check("t1 level after push", {29'd0, if_a.level}, 32'd1);
        check("t1 empty after push", {31'd0, if_a.empty}, 32'd0);
        check("t1 busy before pop",  {31'd0, if_a.busy},  32'd0);
        @(negedge clk);
        check("t1 busy after pop",   {31'd0, if_a.busy},  32'd1);
        check("t1 empty after pop",  {31'd0, if_a.empty}, 32'd1);
        check("t1 level after pop",  {29'd0, if_a.level}, 32'd0);
        check("t1 guard tx",         {31'd0, if_a.tx},    32'd1);
        check_frame("t1 0xAA", 16'h354, 10, w);
        check("t1 guard length", w, CPB);
        check("t1 idle busy", {31'd0, if_a.busy}, 32'd0);

        // Test 4: five pushes in consecutive cycles; the first is popped at
        // once, so all five fit. A sixth push while full is dropped.
        t4_data[0] = 8'hAC; t4_exp[0] = 16'h358;
        t4_data[1] = 8'hAD; t4_exp[1] = 16'h35A;
        t4_data[2] = 8'hAF; t4_exp[2] = 16'h35E;
        t4_data[3] = 8'h00; t4_exp[3] = 16'h200;
        t4_data[4] = 8'h11; t4_exp[4] = 16'h222;
        for (int i = 0; i < 5; i++) begin
            if_a.writedata = t4_data[i];
            if_a.enable    = 1'b1;
            @(negedge clk);
        end
        check("t4 full",            {31'd0, if_a.full},     32'd1);
        check("t4 level full",      {29'd0, if_a.level},    32'd4);
        check("t4 no overflow yet", {31'd0, if_a.overflow}, 32'd0);
        if_a.writedata = 8'h22;
        @(negedge clk);
        if_a.enable = 1'b0;
        check("t4 overflow pulse",  {31'd0, if_a.overflow}, 32'd1);
        check("t4 level kept",      {29'd0, if_a.level},    32'd4);
        @(negedge clk);
        check("t4 overflow ends",   {31'd0, if_a.overflow}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_frame($sformatf("t4 frame%0d", i), t4_exp[i], 10, w);
            if (i > 0) check($sformatf("t4 gap%0d", i), w, 9);
        end
        check("t4 level drained", {29'd0, if_a.level}, 32'd0);
        check("t4 empty drained", {31'd0, if_a.empty}, 32'd1);
        check("t4 busy drained",  {31'd0, if_a.busy},  32'd0);

        // Test 6: FIFO full; a push on the pop edge is accepted.
        t6_data[0] = 8'h01;
        t6_data[1] = 8'h02; t6_exp[0] = 16'h204;
        t6_data[2] = 8'h04; t6_exp[1] = 16'h208;
        t6_data[3] = 8'h08; t6_exp[2] = 16'h210;
        t6_data[4] = 8'h10; t6_exp[3] = 16'h220;
        t6_exp[4] = 16'h300;   // word 0x80 pushed on the pop edge
        for (int i = 0; i < 5; i++) begin
            if_a.writedata = t6_data[i];
            if_a.enable    = 1'b1;
            @(negedge clk);
        end
        if_a.enable = 1'b0;
        check("t6 full before", {31'd0, if_a.full}, 32'd1);
        k = 0;
        while (if_a.done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("t6 done seen", {31'd0, if_a.done}, 32'd1);
        if_a.writedata = 8'h80;
        if_a.enable    = 1'b1;
        @(negedge clk);
        if_a.enable = 1'b0;
        check("t6 level stays", {29'd0, if_a.level},    32'd4);
        check("t6 full stays",  {31'd0, if_a.full},     32'd1);
        check("t6 no overflow", {31'd0, if_a.overflow}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_frame($sformatf("t6 frame%0d", i), t6_exp[i], 10, w);
        end
        check("t6 empty drained", {31'd0, if_a.empty}, 32'd1);

        // Test 2: even parity, two stop bits; 0xAB has five ones -> parity 1
        if_b.writedata = 8'hAB;
        if_b.enable    = 1'b1;
        @(negedge clk);
        if_b.enable = 1'b0;
        sel = 1;
        check_frame("t2 even 0xAB", 16'hF56, 12, w);
        check("t2 even guard", w, CPB + 1);
        // Odd parity -> parity 0
        if_c.writedata = 8'hAB;
        if_c.enable    = 1'b1;
        @(negedge clk);
        if_c.enable = 1'b0;
        sel = 2;
        check_frame("t2 odd 0xAB", 16'hD56, 12, w);

        // Test 3: 7 data bits, 7'h55 -> 1,0,1,0,1,0,1
        if_d.writedata = 7'h55;
        if_d.enable    = 1'b1;
        @(negedge clk);
        if_d.enable = 1'b0;
        sel = 3;
        check_frame("t3 7N1 0x55", 16'h1AA, 9, w);

        // Test 5: reset in the middle of the data bits of a 0xF0 frame
        sel = 0;
        if_a.writedata = 8'hF0;
        if_a.enable    = 1'b1;
        @(negedge clk);
        if_a.enable = 1'b0;
        k = 0;
        while (if_a.tx !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (2 * CPB + 8) @(negedge clk);   // middle of data bit 1 (a 0)
        check("t5 busy in data", {31'd0, if_a.busy}, 32'd1);
        check("t5 tx in data",   {31'd0, if_a.tx},   32'd0);
        rst_n = 1'b0;
        #1;
        check("t5 tx on reset",    {31'd0, if_a.tx},    32'd1);
        check("t5 busy on reset",  {31'd0, if_a.busy},  32'd0);
        check("t5 empty on reset", {31'd0, if_a.empty}, 32'd1);
        check("t5 level on reset", {29'd0, if_a.level}, 32'd0);
        cnt_done = 0;
        cnt_low  = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_a.done === 1'b1) cnt_done++;
            if (if_a.tx !== 1'b1) cnt_low++;
        end
        check("t5 no done after abort", cnt_done, 0);
        check("t5 line idle after abort", cnt_low, 0);
        if_a.writedata = 8'h3C;
        if_a.enable    = 1'b1;
        @(negedge clk);
        if_a.enable = 1'b0;
        check_frame("t5 0x3C", 16'h278, 10, w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
